// File: rtl/viterbi_traceback.sv
// Survivor-path traceback for the Viterbi decoder.
// The block buffers TB_DEPTH decision vectors, traces back from the supplied
// best-metric state, and then streams out the decoded bits oldest-first.
// Trellis: next = {u, s[ST_W-1:1]}, predecessor(s) = {s[ST_W-2:0], d}.
// Optional feature: define VTB_LAST_EN to add o_last, which marks the final
// bit of each block.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   FILL  | accepting decision vectors into mem[0..TB_DEPTH-1]
//   TRACE | walking back one step per cycle, filling the bit buffer
//   EMIT  | presenting bitbuf[cnt] on the output stream
module viterbi_traceback #(
    parameter int ST_W     = 3,
    parameter int TB_DEPTH = 16,
    parameter int CNT_W    = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_dec_vld,
    input  logic [(1<<ST_W)-1:0]   i_dec,
    input  logic [ST_W-1:0]        i_start_st,
    output logic                   o_dec_rdy,
    output logic                   o_bit_vld,
    output logic                   o_bit,
    input  logic                   i_bit_rdy
`ifdef VTB_LAST_EN
    ,
    output logic                   o_last
`endif
);
    localparam int N_ST = 1 << ST_W;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TB_DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = '0;

    typedef enum logic [1:0] {FILL, TRACE, EMIT} state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [ST_W-1:0]      cur_q, cur_d;
    logic                 bit_q, bit_d;
    logic                 bit_vld_q, bit_vld_d;
    logic [N_ST-1:0]      mem_q [TB_DEPTH];
    logic [TB_DEPTH-1:0]  bitbuf_q;
    logic [N_ST-1:0]      mem_rd;
    logic                 dec_acc;
    logic                 bit_xfer;

    assign o_dec_rdy = (state_q == FILL) && !rst;
    assign dec_acc   = i_dec_vld && o_dec_rdy;
    assign bit_xfer  = bit_vld_q && i_bit_rdy;
    assign mem_rd    = mem_q[cnt_q];
    assign o_bit_vld = bit_vld_q;
    assign o_bit     = bit_q;

    // Next-state, counter, traceback state and output-bit selection
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        cur_d     = cur_q;
        bit_d     = bit_q;
        bit_vld_d = bit_vld_q;
        case (state_q)
            FILL: begin
                if (dec_acc) begin
                    if (cnt_q == CNT_LAST) begin
                        cur_d   = i_start_st;
                        cnt_d   = CNT_LAST;
                        state_d = TRACE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            TRACE: begin
                cur_d = {cur_q[ST_W-2:0], mem_rd[cur_q]};
                if (cnt_q == CNT_ZERO) begin
                    // bitbuf[0] is written on this same edge, so forward it
                    bit_d     = cur_q[ST_W-1];
                    bit_vld_d = 1'b1;
                    cnt_d     = CNT_ZERO;
                    state_d   = EMIT;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            EMIT: begin
                if (bit_xfer) begin
                    if (cnt_q == CNT_LAST) begin
                        bit_d     = 1'b0;
                        bit_vld_d = 1'b0;
                        cnt_d     = CNT_ZERO;
                        state_d   = FILL;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                        bit_d = bitbuf_q[cnt_d];
                    end
                end
            end
            default: state_d = FILL;
        endcase
    end

    // Control registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= FILL;
            cnt_q     <= CNT_ZERO;
            cur_q     <= '0;
            bit_q     <= 1'b0;
            bit_vld_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            cur_q     <= cur_d;
            bit_q     <= bit_d;
            bit_vld_q <= bit_vld_d;
        end
    end

    // Decision array and decoded-bit buffer; contents survive reset
    always_ff @(posedge clk) begin
        if (dec_acc) begin
            mem_q[cnt_q] <= i_dec;
        end
        if (state_q == TRACE) begin
            bitbuf_q[cnt_q] <= cur_q[ST_W-1];
        end
    end

`ifdef VTB_LAST_EN
    logic last_q, last_d;

    assign last_d = bit_vld_d && (cnt_d == CNT_LAST);
    assign o_last = last_q;

    // End-of-block marker tracks o_bit, so it holds under backpressure too
    always_ff @(posedge clk) begin
        if (rst) begin
            last_q <= 1'b0;
        end else begin
            last_q <= last_d;
        end
    end
`endif

endmodule

// File: tb/tb_viterbi_traceback.sv
// Directed bench for viterbi_traceback (ST_W=3, TB_DEPTH=16).
module tb_viterbi_traceback;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       i_dec_vld = 1'b0;
    logic [7:0] i_dec = 8'h00;
    logic [2:0] i_start_st = 3'd0;
    logic       i_bit_rdy = 1'b0;
    logic       o_dec_rdy, o_bit_vld, o_bit;
    logic       last_sig;

    viterbi_traceback #(.ST_W(3), .TB_DEPTH(16), .CNT_W(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .i_dec_vld  (i_dec_vld),
        .i_dec      (i_dec),
        .i_start_st (i_start_st),
        .o_dec_rdy  (o_dec_rdy),
        .o_bit_vld  (o_bit_vld),
        .o_bit      (o_bit),
        .i_bit_rdy  (i_bit_rdy)
`ifdef VTB_LAST_EN
        ,
        .o_last     (last_sig)
`endif
    );
`ifndef VTB_LAST_EN
    assign last_sig = 1'b0;
`endif

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int acc_cyc = 0;
    int rise_cyc = -1;
    logic vld_prev = 1'b0;
    logic [7:0] vecs [16];
    logic q [$];
    logic lq [$];

    always @(posedge clk) cyc = cyc + 1;

    // Collect transferred bits and note the first-valid cycle of each block
    always @(negedge clk) begin
        if (!rst && o_bit_vld && i_bit_rdy) begin
            q.push_back(o_bit);
            lq.push_back(last_sig);
        end
        if (o_bit_vld && !vld_prev) rise_cyc = cyc;
        vld_prev = o_bit_vld;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Decisions along the encoder path for word w (bit0 first); other
    // entries get filler so a wrong state lookup shows up.
    task automatic make_enc(input logic [15:0] w);
        logic [2:0] s, n;
        s = 3'd0;
        for (int i = 0; i < 16; i++) begin
            n = {w[i], s[2:1]};
            vecs[i] = 8'h5A ^ 8'(i * 37);
            vecs[i][n] = s[0];
            s = n;
        end
        i_start_st = s;
    endtask

    task automatic make_const(input logic [7:0] v, input logic [2:0] st);
        for (int i = 0; i < 16; i++) vecs[i] = v;
        i_start_st = st;
    endtask

    // Called just after a rising edge; returns just after the last accept edge
    task automatic feed(input bit hold_ff);
        bit acc;
        int n;
        for (int i = 0; i < 16; i++) begin
            i_dec_vld = 1'b1;
            i_dec = vecs[i];
            acc = 1'b0;
            n = 0;
            while (!acc && n < 200) begin
                @(negedge clk);
                if (o_dec_rdy) begin
                    acc = 1'b1;
                    acc_cyc = cyc;
                end
                @(posedge clk);
                #1;
                n++;
            end
            check($sformatf("feed_acc%0d", i), 32'(acc), 32'd1);
        end
        if (hold_ff) i_dec = 8'hFF;
        else i_dec_vld = 1'b0;
    endtask

    task automatic drain(input string tag, input logic [31:0] exp, input int n);
        int k;
        k = 0;
        while (q.size() < n && k < 400) begin
            @(posedge clk);
            #1;
            k++;
        end
        check({tag, "_cnt"}, 32'(q.size()), 32'(n));
        for (int i = 0; i < n && i < q.size(); i++) begin
            check($sformatf("%s_bit%0d", tag, i), 32'(q[i]), 32'(exp[i]));
`ifdef VTB_LAST_EN
            check($sformatf("%s_last%0d", tag, i), 32'(lq[i]), 32'((i % 16) == 15));
`endif
        end
        q.delete();
        lq.delete();
    endtask

    initial begin
        int acc_c, k;
        // Reset behaviour
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_rdy", 32'(o_dec_rdy), 32'd0);
        check("rst_vld", 32'(o_bit_vld), 32'd0);
        check("rst_bit", 32'(o_bit), 32'd0);
        check("rst_last", 32'(last_sig), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("post_rst_rdy", 32'(o_dec_rdy), 32'd1);
        @(posedge clk);
        #1;

        // All-zero decisions from state 0
        i_bit_rdy = 1'b1;
        make_const(8'h00, 3'd0);
        feed(1'b0);
        drain("zero", 32'h0000, 16);
        repeat (3) @(posedge clk);
        #1;
        check("zero_extra", 32'(q.size()), 32'd0);
        check("zero_idle_vld", 32'(o_bit_vld), 32'd0);

        // Zero decisions from state 5: shifts out 1,0,1 at the newest end
        make_const(8'h00, 3'd5);
        feed(1'b0);
        drain("st5", 32'h0000A000, 16);

        // Encoded word: 0,1,0,1,0,0,1,1,0,0,0,0,1,1,0,1
        make_enc(16'hB0CA);
        feed(1'b0);
        drain("b0ca", 32'h0000B0CA, 16);
        check("b0ca_latency", 32'(rise_cyc - acc_cyc), 32'd17);

        // Backpressure after the third bit
        i_bit_rdy = 1'b0;
        make_enc(16'h6E29);
        feed(1'b0);
        k = 0;
        while (!o_bit_vld && k < 100) begin
            @(negedge clk);
            k++;
        end
        check("bp_vld_seen", 32'(o_bit_vld), 32'd1);
        @(posedge clk);
        #1 i_bit_rdy = 1'b1;
        repeat (3) @(posedge clk);
        #1 i_bit_rdy = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check($sformatf("bp_hold_vld%0d", i), 32'(o_bit_vld), 32'd1);
            check($sformatf("bp_hold_bit%0d", i), 32'(o_bit), 32'd1);
            check($sformatf("bp_hold_last%0d", i), 32'(last_sig), 32'd0);
        end
        @(posedge clk);
        #1 i_bit_rdy = 1'b1;
        drain("bp", 32'h00006E29, 16);
        repeat (3) @(posedge clk);
        #1;
        check("bp_extra", 32'(q.size()), 32'd0);

        // i_dec_vld held high with 8'hFF through TRACE/EMIT
        make_enc(16'h0F35);
        feed(1'b1);
        drain("hold_a", 32'h00000F35, 16);
        make_enc(16'hC3A6);
        feed(1'b0);
        drain("hold_b", 32'h0000C3A6, 16);

        // Reset in the middle of TRACE discards the block
        make_enc(16'h9C47);
        feed(1'b0);
        repeat (7) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check("mid_rst_rdy", 32'(o_dec_rdy), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("after_rst_vld", 32'(o_bit_vld), 32'd0);
        check("after_rst_rdy", 32'(o_dec_rdy), 32'd1);
        repeat (40) @(posedge clk);
        #1;
        check("after_rst_no_out", 32'(q.size()), 32'd0);
        make_enc(16'h2B7D);
        feed(1'b0);
        drain("fresh", 32'h00002B7D, 16);

        // Two back-to-back blocks
        make_enc(16'hE4D1);
        feed(1'b0);
        acc_c = acc_cyc;
        make_enc(16'h5A3C);
        feed(1'b0);
        check("b2b_latency1", 32'(rise_cyc - acc_c), 32'd17);
        drain("b2b", 32'h5A3CE4D1, 32);
        check("b2b_latency2", 32'(rise_cyc - acc_cyc), 32'd17);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
